stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
- Initiator side of the operand-stack interface, sitting between the control unit (UC) and the 16-deep operand stack.
- Accepts one stack-machine command at a time over a valid/ready handshake and converts it into a legal sequence of push/pop strobes.
- Captures popped operands, evaluates binary operations in an internal ALU, pushes results back, and reports completion or error.

Parameters:
DATA_W, 16, operand width; stack word and UC immediate width.
RES_W, 32, ALU result width forwarded to the stack's ALU data input.
DEPTH, 16, stack capacity in words; used for the overflow check against stk_tos.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
cmd_valid  in  1  command offered by UC.
cmd_ready  out  1  high only in IDLE.
cmd_op  in  3  0=PUSH_IMM, 1=POP, 2=ADD, 3=SUB, 4=AND, 5=OR, 6=DUP, 7=illegal.
cmd_imm  in  DATA_W  immediate for PUSH_IMM.
done  out  1  one-cycle pulse when a command retires.
err  out  1  valid with done; 1 means underflow, overflow or illegal op.
result_data  out  DATA_W  word popped by POP; holds until the next POP retires.
stk_push  out  1  push strobe; word written at tos, tos increments.
stk_pop  out  1  pop strobe; stk_dout is valid on the next cycle, tos decrements.
stk_src_alu  out  1  0 selects stk_din_uc, 1 selects stk_din_alu for the push.
stk_din_uc  out  DATA_W  UC-side push data.
stk_din_alu  out  RES_W  ALU-side push data.
stk_dout  in  DATA_W  registered stack read data.
stk_tos  in  16  current stack occupancy.

Behaviour:
- Reset: state IDLE; done=0, err=0, result_data=0; operand registers opa and opb = 0. stk_push, stk_pop, stk_src_alu, stk_din_uc and stk_din_alu all read 0 from the cycle after rst is sampled high. Reset mid-command aborts it; no further strobes and no done.
- Strobes are decoded from state. stk_push and stk_pop are never high together; both are 0 in IDLE.
- Accept: cmd_valid and cmd_ready at a clock edge latch cmd_op and cmd_imm. The legality check runs in the same cycle against stk_tos:
  - PUSH_IMM requires tos < DEPTH.
  - POP requires tos >= 1.
  - DUP requires 1 <= tos < DEPTH.
  - ADD, SUB, AND, OR require tos >= 2.
  - op 7 is always illegal.
- Illegal or failed check: go to ERR. The next cycle pulses done=1, err=1, issues no strobes, and returns to IDLE. Latency is 1.
- States: IDLE, POP1, POP2, CAPA, CAPD, PUSHU, PUSHU2, PUSHA, ERR, DONE.
- PUSH_IMM: IDLE -> PUSHU (stk_push=1, src_alu=0, stk_din_uc=imm) -> DONE (done=1). done arrives 2 cycles after accept.
- POP: IDLE -> POP1 (stk_pop=1) -> CAPD (result_data <= stk_dout) -> DONE. done arrives 3 cycles after accept.
- DUP: POP1 -> CAPD (opa <= stk_dout) -> PUSHU (push opa) -> PUSHU2 (push opa) -> DONE. Net tos +1; done arrives 5 cycles after accept.
- Binary op: POP1 (pop) -> POP2 (opb <= stk_dout, pop) -> CAPA (opa <= stk_dout) -> PUSHA (stk_push=1, src_alu=1, stk_din_alu=ALU(opa,opb)) -> DONE. done arrives 5 cycles after accept; net tos -1.
- Operand order: the first pop is the right operand (opb); SUB computes opa - opb.
- ALU arithmetic, combinational from opa/opb:
  - ADD: zero-extend both operands to RES_W and add; bit 16 is the carry.
  - SUB: zero-extended difference mod 2^RES_W, so 1-2 = 32'hFFFFFFFF.
  - AND, OR: zero-extended to RES_W.
- DONE lasts one cycle with done=1, err=0, then returns to IDLE. cmd_ready rises in the cycle after DONE; back-to-back commands are spaced by the command latency plus 1.
- stk_din_uc and stk_din_alu are 0 whenever the corresponding push is not active.

Decomposition:
- Shared package: opcode constants (OP_PUSH_IMM..OP_ILLEGAL), state encoding, DATA_W/RES_W/DEPTH defaults, and the ALU-op encoding.
- One sub-module: stack_alu. Combinational; inputs opa, opb and op; output is the RES_W result.
- The sequencer FSM, operand registers and legality check stay in stack_sequencer.

Test Plan:
- PUSH_IMM 16'h0005 at tos=0 -> one cycle later stk_push=1, src_alu=0, stk_din_uc=5; done=1, err=0 at accept+2.
- PUSH 7, PUSH 3, SUB -> pops in two consecutive cycles; push with stk_din_alu=32'h00000004; tos goes 2 -> 0 -> 1; done at accept+5.
- PUSH 16'hFFFF, PUSH 16'h0001, ADD -> stk_din_alu=32'h00010000.
- PUSH 1, PUSH 2, SUB -> stk_din_alu=32'hFFFFFFFF.
- POP at tos=0, and ADD at tos=1 -> no strobes; done=1, err=1 at accept+1; op 7 gives the same response.
- tos=16, PUSH_IMM -> err=1; POP at tos=1 holding 16'hABCD -> result_data=16'hABCD. rst asserted in POP2 -> no push, no done; cmd_ready=1 after reset.

Source files
------------

// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the operand-stack sequencer: opcodes, FSM states,
// ALU operation encoding and the command legality check.
package stack_sequencer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int RES_W_DEF  = 32;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [2:0] {
    OP_PUSH_IMM = 3'd0,
    OP_POP      = 3'd1,
    OP_ADD      = 3'd2,
    OP_SUB      = 3'd3,
    OP_AND      = 3'd4,
    OP_OR       = 3'd5,
    OP_DUP      = 3'd6,
    OP_ILLEGAL  = 3'd7
  } cmd_op_e;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_POP1   = 4'd1,
    ST_POP2   = 4'd2,
    ST_CAPA   = 4'd3,
    ST_CAPD   = 4'd4,
    ST_PUSHU  = 4'd5,
    ST_PUSHU2 = 4'd6,
    ST_PUSHA  = 4'd7,
    ST_ERR    = 4'd8,
    ST_DONE   = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  function automatic alu_op_e alu_op_of(input logic [2:0] op);
    alu_op_e res;
    case (op)
      OP_SUB:  res = ALU_SUB;
      OP_AND:  res = ALU_AND;
      OP_OR:   res = ALU_OR;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // Checks the command against the occupancy seen in the accept cycle.
  function automatic logic op_legal(input logic [2:0] op, input logic [15:0] tos,
                                    input logic [15:0] depth);
    logic ok;
    case (op)
      OP_PUSH_IMM:                   ok = (tos < depth);
      OP_POP:                        ok = (tos >= 16'd1);
      OP_DUP:                        ok = (tos >= 16'd1) && (tos < depth);
      OP_ADD, OP_SUB, OP_AND, OP_OR: ok = (tos >= 16'd2);
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for binary stack ops; operands are zero-extended, so SUB
// wraps modulo 2^RES_W and ADD exposes the carry in bit DATA_W.
module stack_alu
  import stack_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
) (
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  alu_op_e           op,
  output logic [RES_W-1:0]  result
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  always_comb begin
    a_ext  = RES_W'(opa);
    b_ext  = RES_W'(opb);
    result = '0;
    case (op)
      ALU_ADD: result = a_ext + b_ext;
      ALU_SUB: result = a_ext - b_ext;
      ALU_AND: result = a_ext & b_ext;
      ALU_OR:  result = a_ext | b_ext;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stack_sequencer.sv
// Control-unit side sequencer for the operand stack: turns one command at a
// time into push/pop strobes, captures operands and pushes ALU results.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result_data,
  output logic              stk_push,
  output logic              stk_pop,
  output logic              stk_src_alu,
  output logic [DATA_W-1:0] stk_din_uc,
  output logic [RES_W-1:0]  stk_din_alu,
  input  logic [DATA_W-1:0] stk_dout,
  input  logic [15:0]       stk_tos
);

  state_e            state_r;
  state_e            state_s;
  logic [2:0]        op_r;
  logic [DATA_W-1:0] imm_r;
  logic [DATA_W-1:0] opa_r;
  logic [DATA_W-1:0] opb_r;
  logic [DATA_W-1:0] result_r;
  logic [RES_W-1:0]  alu_res_s;

  stack_alu #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_alu (
    .opa    (opa_r),
    .opb    (opb_r),
    .op     (alu_op_of(op_r)),
    .result (alu_res_s)
  );

  // State register, command latch and operand capture from the registered stack read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      op_r     <= 3'd0;
      imm_r    <= '0;
      opa_r    <= '0;
      opb_r    <= '0;
      result_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE && cmd_valid) begin
        op_r  <= cmd_op;
        imm_r <= cmd_imm;
      end
      case (state_r)
        ST_POP2: opb_r <= stk_dout;
        ST_CAPA: opa_r <= stk_dout;
        ST_CAPD: begin
          if (op_r == OP_POP) begin
            result_r <= stk_dout;
          end else begin
            opa_r <= stk_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and state-decoded strobes; push data is zero unless its push is active.
  always_comb begin
    state_s     = state_r;
    cmd_ready   = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_src_alu = 1'b0;
    stk_din_uc  = '0;
    stk_din_alu = '0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!op_legal(cmd_op, stk_tos, 16'(DEPTH))) begin
            state_s = ST_ERR;
          end else begin
            state_s = (cmd_op == OP_PUSH_IMM) ? ST_PUSHU : ST_POP1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_POP1: begin
        stk_pop = 1'b1;
        state_s = (op_r == OP_POP || op_r == OP_DUP) ? ST_CAPD : ST_POP2;
      end
      ST_POP2: begin
        stk_pop = 1'b1;
        state_s = ST_CAPA;
      end
      ST_CAPA: state_s = ST_PUSHA;
      ST_CAPD: state_s = (op_r == OP_DUP) ? ST_PUSHU : ST_DONE;
      ST_PUSHU: begin
        stk_push   = 1'b1;
        stk_din_uc = (op_r == OP_DUP) ? opa_r : imm_r;
        state_s    = (op_r == OP_DUP) ? ST_PUSHU2 : ST_DONE;
      end
      ST_PUSHU2: begin
        stk_push   = 1'b1;
        stk_din_uc = opa_r;
        state_s    = ST_DONE;
      end
      ST_PUSHA: begin
        stk_push    = 1'b1;
        stk_src_alu = 1'b1;
        stk_din_alu = alu_res_s;
        state_s     = ST_DONE;
      end
      ST_ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_s = ST_IDLE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign result_data = result_r;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural 16-deep stack model.
module tb_stack_sequencer;
  import stack_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_imm;
  logic        done;
  logic        err;
  logic [15:0] result_data;
  logic        stk_push;
  logic        stk_pop;
  logic        stk_src_alu;
  logic [15:0] stk_din_uc;
  logic [31:0] stk_din_alu;
  logic [15:0] stk_dout;
  logic [15:0] m_tos;
  logic [15:0] mem [0:15];
  logic        load_en;
  logic [15:0] load_val;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stack_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_imm     (cmd_imm),
    .done        (done),
    .err         (err),
    .result_data (result_data),
    .stk_push    (stk_push),
    .stk_pop     (stk_pop),
    .stk_src_alu (stk_src_alu),
    .stk_din_uc  (stk_din_uc),
    .stk_din_alu (stk_din_alu),
    .stk_dout    (stk_dout),
    .stk_tos     (m_tos)
  );

  // Stack model: push writes at tos, pop returns the top word one cycle later.
  always @(posedge clk) begin
    if (load_en) begin
      m_tos <= load_val;
    end else if (stk_push) begin
      mem[m_tos[3:0]] <= stk_src_alu ? stk_din_alu[15:0] : stk_din_uc;
      m_tos <= m_tos + 16'd1;
    end else if (stk_pop) begin
      stk_dout <= mem[m_tos[3:0] - 4'd1];
      m_tos <= m_tos - 16'd1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    load_en = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Offers one command; returns at the negedge of the first cycle after acceptance.
  task automatic send(input logic [2:0] op, input logic [15:0] imm);
    int k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_imm = 16'd0;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [15:0] imm);
    int k = 0;
    send(op, imm);
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL do_cmd_done: done=%b required 1 (op %0d)", done, op);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    tests++;
    if ({cmd_ready, done, err, stk_push, stk_pop, stk_src_alu} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctrl: ready/done/err/push/pop/src=%b required 100000",
               {cmd_ready, done, err, stk_push, stk_pop, stk_src_alu});
    end
    tests++;
    if ({result_data, stk_din_uc, stk_din_alu} !== 64'd0) begin
      fails++;
      $display("FAIL reset_data: result=%h din_uc=%h din_alu=%h required 0",
               result_data, stk_din_uc, stk_din_alu);
    end
    rst = 1'b0;
    load(16'd0);
  endtask

  task automatic test_push_imm;
    send(OP_PUSH_IMM, 16'h0005);
    tests++;
    if ({stk_push, stk_pop, stk_src_alu, done, err} !== 5'b10000 || stk_din_uc !== 16'h0005 ||
        stk_din_alu !== 32'd0) begin
      fails++;
      $display("FAIL push_strobe: push/pop/src/done/err=%b din_uc=%h din_alu=%h required 10000 0005 0",
               {stk_push, stk_pop, stk_src_alu, done, err}, stk_din_uc, stk_din_alu);
    end
    step(1);
    tests++;
    if ({stk_push, stk_pop, stk_src_alu, done, err} !== 5'b00010 || m_tos !== 16'd1) begin
      fails++;
      $display("FAIL push_done: strobes=%b tos=%0d required 00010 tos 1",
               {stk_push, stk_pop, stk_src_alu, done, err}, m_tos);
    end
    step(1);
    tests++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL push_ready: ready=%b done=%b required 1 0", cmd_ready, done);
    end
  endtask

  task automatic test_sub;
    load(16'd0);
    do_cmd(OP_PUSH_IMM, 16'd7);
    do_cmd(OP_PUSH_IMM, 16'd3);
    send(OP_SUB, 16'd0);
    tests++;
    if ({stk_push, stk_pop, done} !== 3'b010 || m_tos !== 16'd2) begin
      fails++;
      $display("FAIL sub_pop1: push/pop/done=%b tos=%0d required 010 tos 2", {stk_push, stk_pop, done}, m_tos);
    end
    step(1);
    tests++;
    if ({stk_push, stk_pop, done} !== 3'b010) begin
      fails++;
      $display("FAIL sub_pop2: push/pop/done=%b required 010", {stk_push, stk_pop, done});
    end
    step(1);
    tests++;
    if ({stk_push, stk_pop, done} !== 3'b000 || m_tos !== 16'd0) begin
      fails++;
      $display("FAIL sub_cap: push/pop/done=%b tos=%0d required 000 tos 0", {stk_push, stk_pop, done}, m_tos);
    end
    step(1);
    tests++;
    if ({stk_push, stk_pop, stk_src_alu, done} !== 4'b1010 || stk_din_alu !== 32'h00000004 ||
        stk_din_uc !== 16'd0) begin
      fails++;
      $display("FAIL sub_push: push/pop/src/done=%b din_alu=%h din_uc=%h required 1010 00000004 0",
               {stk_push, stk_pop, stk_src_alu, done}, stk_din_alu, stk_din_uc);
    end
    step(1);
    tests++;
    if ({done, err} !== 2'b10 || m_tos !== 16'd1 || mem[0] !== 16'd4) begin
      fails++;
      $display("FAIL sub_done: done/err=%b tos=%0d top=%h required 10 tos 1 top 0004",
               {done, err}, m_tos, mem[0]);
    end
    step(1);
  endtask

  task automatic test_alu_edges;
    load(16'd0);
    do_cmd(OP_PUSH_IMM, 16'hFFFF);
    do_cmd(OP_PUSH_IMM, 16'h0001);
    send(OP_ADD, 16'd0);
    step(3);
    tests++;
    if (stk_push !== 1'b1 || stk_din_alu !== 32'h00010000) begin
      fails++;
      $display("FAIL add_carry: push=%b din_alu=%h required 1 00010000", stk_push, stk_din_alu);
    end
    step(2);
    load(16'd0);
    do_cmd(OP_PUSH_IMM, 16'd1);
    do_cmd(OP_PUSH_IMM, 16'd2);
    send(OP_SUB, 16'd0);
    step(3);
    tests++;
    if (stk_push !== 1'b1 || stk_din_alu !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL sub_wrap: push=%b din_alu=%h required 1 ffffffff", stk_push, stk_din_alu);
    end
    step(2);
    load(16'd0);
    do_cmd(OP_PUSH_IMM, 16'hF0F0);
    do_cmd(OP_PUSH_IMM, 16'h3C3C);
    send(OP_AND, 16'd0);
    step(3);
    tests++;
    if (stk_din_alu !== 32'h00003030) begin
      fails++;
      $display("FAIL and_op: din_alu=%h required 00003030", stk_din_alu);
    end
    step(2);
    do_cmd(OP_PUSH_IMM, 16'h0C03);
    send(OP_OR, 16'd0);
    step(3);
    tests++;
    if (stk_din_alu !== 32'h00003C33) begin
      fails++;
      $display("FAIL or_op: din_alu=%h required 00003c33", stk_din_alu);
    end
    step(2);
  endtask

  task automatic test_errors;
    logic [2:0]  eop  [4];
    logic [15:0] etos [4];
    eop  = '{OP_POP, OP_ADD, OP_ILLEGAL, OP_PUSH_IMM};
    etos = '{16'd0, 16'd1, 16'd5, 16'd16};
    for (int i = 0; i < 4; i++) begin
      load(etos[i]);
      send(eop[i], 16'h1111);
      tests++;
      if ({stk_push, stk_pop, done, err} !== 4'b0011) begin
        fails++;
        $display("FAIL err_resp%0d: push/pop/done/err=%b required 0011", i, {stk_push, stk_pop, done, err});
      end
      step(1);
      tests++;
      if ({cmd_ready, done, err} !== 3'b100 || m_tos !== etos[i]) begin
        fails++;
        $display("FAIL err_after%0d: ready/done/err=%b tos=%0d required 100 tos %0d",
                 i, {cmd_ready, done, err}, m_tos, etos[i]);
      end
    end
  endtask

  task automatic test_pop;
    load(16'd0);
    do_cmd(OP_PUSH_IMM, 16'hABCD);
    send(OP_POP, 16'd0);
    tests++;
    if ({stk_push, stk_pop, done} !== 3'b010) begin
      fails++;
      $display("FAIL pop_strobe: push/pop/done=%b required 010", {stk_push, stk_pop, done});
    end
    step(2);
    tests++;
    if ({done, err} !== 2'b10 || result_data !== 16'hABCD || m_tos !== 16'd0) begin
      fails++;
      $display("FAIL pop_done: done/err=%b result=%h tos=%0d required 10 abcd tos 0",
               {done, err}, result_data, m_tos);
    end
    step(1);
    do_cmd(OP_PUSH_IMM, 16'h1234);
    tests++;
    if (result_data !== 16'hABCD) begin
      fails++;
      $display("FAIL pop_hold: result=%h required abcd", result_data);
    end
  endtask

  task automatic test_dup;
    load(16'd0);
    do_cmd(OP_PUSH_IMM, 16'h0009);
    send(OP_DUP, 16'd0);
    tests++;
    if ({stk_push, stk_pop} !== 2'b01) begin
      fails++;
      $display("FAIL dup_pop: push/pop=%b required 01", {stk_push, stk_pop});
    end
    step(2);
    tests++;
    if ({stk_push, stk_src_alu, done} !== 3'b100 || stk_din_uc !== 16'h0009) begin
      fails++;
      $display("FAIL dup_push1: push/src/done=%b din_uc=%h required 100 0009", {stk_push, stk_src_alu, done}, stk_din_uc);
    end
    step(1);
    tests++;
    if ({stk_push, stk_src_alu, done} !== 3'b100 || stk_din_uc !== 16'h0009) begin
      fails++;
      $display("FAIL dup_push2: push/src/done=%b din_uc=%h required 100 0009", {stk_push, stk_src_alu, done}, stk_din_uc);
    end
    step(1);
    tests++;
    if ({done, err} !== 2'b10 || m_tos !== 16'd2 || mem[1] !== 16'h0009) begin
      fails++;
      $display("FAIL dup_done: done/err=%b tos=%0d top=%h required 10 tos 2 top 0009", {done, err}, m_tos, mem[1]);
    end
    step(1);
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp_push;
    logic [5:0] exp_done;
    logic [5:0] got_push;
    logic [5:0] got_done;
    exp_push = 6'b001001;
    exp_done = 6'b010010;
    got_push = 6'd0;
    got_done = 6'd0;
    load(16'd0);
    cmd_valid = 1'b1;
    cmd_op = OP_PUSH_IMM;
    cmd_imm = 16'h0011;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      got_push[k] = stk_push;
      got_done[k] = done;
    end
    cmd_valid = 1'b0;
    tests++;
    if (got_push !== exp_push || got_done !== exp_done || m_tos !== 16'd2) begin
      fails++;
      $display("FAIL back_to_back: push=%b done=%b tos=%0d required %b %b tos 2",
               got_push, got_done, m_tos, exp_push, exp_done);
    end
    step(1);
  endtask

  task automatic test_reset_mid;
    logic bad;
    load(16'd0);
    do_cmd(OP_PUSH_IMM, 16'd7);
    do_cmd(OP_PUSH_IMM, 16'd3);
    send(OP_SUB, 16'd0);
    step(1);
    rst = 1'b1;
    step(1);
    tests++;
    if ({stk_push, stk_pop, stk_src_alu, done, err} !== 5'b00000 || {stk_din_uc, stk_din_alu} !== 48'd0) begin
      fails++;
      $display("FAIL rst_mid_strobes: strobes=%b din_uc=%h din_alu=%h required 00000 0 0",
               {stk_push, stk_pop, stk_src_alu, done, err}, stk_din_uc, stk_din_alu);
    end
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (stk_push || done) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0 || cmd_ready !== 1'b1 || m_tos !== 16'd0) begin
      fails++;
      $display("FAIL rst_mid_after: spurious=%b ready=%b tos=%0d required 0 1 tos 0", bad, cmd_ready, m_tos);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_imm = 16'd0;
    load_en = 1'b0;
    load_val = 16'd0;
    @(negedge clk);
    test_reset;
    test_push_imm;
    test_sub;
    test_alu_edges;
    test_errors;
    test_pop;
    test_dup;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
